// File: rtl/vfu_result_wb_buffer.sv
// Buffers ALU and MFPU result writes in per-source FIFOs and round-robins them onto one VRF port.
// Define VFU_WB_BYPASS_EN to let a write reach the VRF in its arrival cycle when nothing is buffered.
module vfu_result_wb_buffer #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned IdWidth   = 3,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_req_i,
    input  logic [IdWidth-1:0]     alu_id_i,
    input  logic [AddrWidth-1:0]   alu_addr_i,
    input  logic [DataWidth-1:0]   alu_wdata_i,
    input  logic [DataWidth/8-1:0] alu_be_i,
    output logic                   alu_gnt_o,
    input  logic                   mfpu_req_i,
    input  logic [IdWidth-1:0]     mfpu_id_i,
    input  logic [AddrWidth-1:0]   mfpu_addr_i,
    input  logic [DataWidth-1:0]   mfpu_wdata_i,
    input  logic [DataWidth/8-1:0] mfpu_be_i,
    output logic                   mfpu_gnt_o,
    output logic                   vrf_req_o,
    output logic [IdWidth-1:0]     vrf_id_o,
    output logic [AddrWidth-1:0]   vrf_addr_o,
    output logic [DataWidth-1:0]   vrf_wdata_o,
    output logic [DataWidth/8-1:0] vrf_be_o,
    output logic                   vrf_src_o,
    input  logic                   vrf_gnt_i,
    output logic [CntWidth-1:0]    alu_cnt_o,
    output logic [CntWidth-1:0]    mfpu_cnt_o,
    output logic                   idle_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned BeWidth  = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
        logic [BeWidth-1:0]   be;
    } entry_t;

    // Index 0 is the ALU, index 1 the MFPU throughout.
    entry_t              in_e   [2];
    entry_t              mem_q  [2][Depth];
    logic [CntWidth-1:0] cnt_q  [2];
    logic [PtrWidth-1:0] wptr_q [2];
    logic [PtrWidth-1:0] rptr_q [2];
    logic                last_src_q, lock_q, lock_src_q;

    logic [1:0] in_req, in_gnt, ne, push, pop, sel_oh;
    logic       sel, req, byp;
    entry_t     head;

    assign in_e[0] = '{id: alu_id_i, addr: alu_addr_i, wdata: alu_wdata_i, be: alu_be_i};
    assign in_e[1] = '{id: mfpu_id_i, addr: mfpu_addr_i, wdata: mfpu_wdata_i, be: mfpu_be_i};
    assign in_req  = {mfpu_req_i, alu_req_i};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_gnt[i] = in_req[i] & (cnt_q[i] < CntWidth'(Depth));
            ne[i]     = (cnt_q[i] != '0);
        end
    end

    always_comb begin
        sel  = 1'b0;
        req  = 1'b0;
        byp  = 1'b0;
        head = '0;
        if (lock_q) begin
            sel = lock_src_q;
            req = ne[lock_src_q];
        end else if (&ne) begin
            sel = ~last_src_q;
            req = 1'b1;
        end else if (ne[0]) begin
            sel = 1'b0;
            req = 1'b1;
        end else if (ne[1]) begin
            sel = 1'b1;
            req = 1'b1;
        end
`ifdef VFU_WB_BYPASS_EN
        else if (|in_req) begin
            byp = 1'b1;
            req = 1'b1;
            sel = (&in_req) ? ~last_src_q : ~in_req[0];
        end
`endif
        if (req) head = byp ? in_e[sel] : mem_q[sel][rptr_q[sel]];
    end

    // A bypassed write that the VRF takes immediately never enters its FIFO.
    assign sel_oh = {sel, ~sel};
    assign push   = in_gnt & ~({2{byp & vrf_gnt_i}} & sel_oh);
    assign pop    = {2{req & vrf_gnt_i & ~byp}} & sel_oh;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            last_src_q <= 1'b1;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + CntWidth'(push[i]) - CntWidth'(pop[i]);
            end
            if (req) begin
                if (vrf_gnt_i) begin
                    last_src_q <= sel;
                    lock_q     <= 1'b0;
                end else begin
                    lock_q     <= 1'b1;
                    lock_src_q <= sel;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem_q[i][wptr_q[i]] <= in_e[i];
        end
    end

    assign alu_gnt_o   = in_gnt[0];
    assign mfpu_gnt_o  = in_gnt[1];
    assign vrf_req_o   = req;
    assign vrf_src_o   = sel;
    assign vrf_id_o    = head.id;
    assign vrf_addr_o  = head.addr;
    assign vrf_wdata_o = head.wdata;
    assign vrf_be_o    = head.be;
    assign alu_cnt_o   = cnt_q[0];
    assign mfpu_cnt_o  = cnt_q[1];
    assign idle_o      = ~ne[0] & ~ne[1] & ~req;

endmodule

// File: tb/tb_vfu_result_wb_buffer.sv
// Scoreboard bench for vfu_result_wb_buffer: drivers queue expected writes, a monitor checks VRF output.
module tb_vfu_result_wb_buffer;

`ifdef VFU_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_req_i = 1'b0, mfpu_req_i = 1'b0;
    logic [2:0]  alu_id_i = '0, mfpu_id_i = '0;
    logic [9:0]  alu_addr_i = '0, mfpu_addr_i = '0;
    logic [63:0] alu_wdata_i = '0, mfpu_wdata_i = '0;
    logic [7:0]  alu_be_i = '0, mfpu_be_i = '0;
    logic        alu_gnt_o, mfpu_gnt_o;
    logic        vrf_req_o, vrf_src_o;
    logic [2:0]  vrf_id_o;
    logic [9:0]  vrf_addr_o;
    logic [63:0] vrf_wdata_o;
    logic [7:0]  vrf_be_o;
    logic        vrf_gnt_i = 1'b1;
    logic [1:0]  alu_cnt_o, mfpu_cnt_o;
    logic        idle_o;

    vfu_result_wb_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_req_i(alu_req_i), .alu_id_i(alu_id_i), .alu_addr_i(alu_addr_i),
        .alu_wdata_i(alu_wdata_i), .alu_be_i(alu_be_i), .alu_gnt_o(alu_gnt_o),
        .mfpu_req_i(mfpu_req_i), .mfpu_id_i(mfpu_id_i), .mfpu_addr_i(mfpu_addr_i),
        .mfpu_wdata_i(mfpu_wdata_i), .mfpu_be_i(mfpu_be_i), .mfpu_gnt_o(mfpu_gnt_o),
        .vrf_req_o(vrf_req_o), .vrf_id_o(vrf_id_o), .vrf_addr_o(vrf_addr_o),
        .vrf_wdata_o(vrf_wdata_o), .vrf_be_o(vrf_be_o), .vrf_src_o(vrf_src_o),
        .vrf_gnt_i(vrf_gnt_i), .alu_cnt_o(alu_cnt_o), .mfpu_cnt_o(mfpu_cnt_o),
        .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [84:0] pay_t;  // {id, addr, wdata, be}
    pay_t alu_exp[$];
    pay_t mfpu_exp[$];
    logic src_log[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected write of the presented source on every accepted write, and
    // checks that a stalled presentation is held unchanged into the next cycle.
    logic held = 1'b0;
    logic [85:0] held_val;
    always @(negedge clk_i) begin
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (held) check("stall_stable", {9'd0, vrf_req_o, vrf_src_o, vrf_id_o, vrf_addr_o,
                                             vrf_wdata_o, vrf_be_o}, {9'd0, 1'b1, held_val});
            held = vrf_req_o & ~vrf_gnt_i;
            held_val = {vrf_src_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o};
            if (vrf_req_o && vrf_gnt_i) begin
                src_log.push_back(vrf_src_o);
                if ((vrf_src_o ? mfpu_exp.size() : alu_exp.size()) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got src %0d addr %0h expected none",
                             vrf_src_o, vrf_addr_o);
                end else begin
                    check(vrf_src_o ? "mfpu_payload" : "alu_payload",
                          {11'd0, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o},
                          {11'd0, vrf_src_o ? mfpu_exp.pop_front() : alu_exp.pop_front()});
                end
            end
        end
    end

    task automatic send_alu(input logic [2:0] id, input logic [9:0] addr,
                            input logic [63:0] data, input logic [7:0] be);
        int n = 0;
        bit done = 0;
        alu_exp.push_back({id, addr, data, be});
        alu_req_i = 1'b1; alu_id_i = id; alu_addr_i = addr; alu_wdata_i = data; alu_be_i = be;
        while (!done) begin
            @(negedge clk_i);
            if (alu_gnt_o) done = 1;
            else if (++n > 50) begin
                tests++; fails++; done = 1;
                $display("FAIL alu_gnt_timeout: got no grant expected grant within 50 cycles");
            end
        end
        @(posedge clk_i); #1;
        alu_req_i = 1'b0;
    endtask

    task automatic send_mfpu(input logic [2:0] id, input logic [9:0] addr,
                             input logic [63:0] data, input logic [7:0] be);
        int n = 0;
        bit done = 0;
        mfpu_exp.push_back({id, addr, data, be});
        mfpu_req_i = 1'b1; mfpu_id_i = id; mfpu_addr_i = addr; mfpu_wdata_i = data;
        mfpu_be_i = be;
        while (!done) begin
            @(negedge clk_i);
            if (mfpu_gnt_o) done = 1;
            else if (++n > 50) begin
                tests++; fails++; done = 1;
                $display("FAIL mfpu_gnt_timeout: got no grant expected grant within 50 cycles");
            end
        end
        @(posedge clk_i); #1;
        mfpu_req_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alu_exp.delete();
        mfpu_exp.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((alu_exp.size() + mfpu_exp.size()) != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 96'(alu_exp.size() + mfpu_exp.size()), 96'd0);
    endtask

    initial begin
        // Reset state
        @(posedge clk_i); #1;
        do_reset();
        @(negedge clk_i);
        check("rst_vrf_req", 96'(vrf_req_o), 96'd0);
        check("rst_src", 96'(vrf_src_o), 96'd0);
        check("rst_wdata", 96'(vrf_wdata_o), 96'd0);
        check("rst_cnts", 96'({alu_cnt_o, mfpu_cnt_o}), 96'd0);
        check("rst_idle", 96'(idle_o), 96'd1);
        check("rst_gnts", 96'({alu_gnt_o, mfpu_gnt_o}), 96'd0);

        // Single ALU write and its presentation latency
        @(posedge clk_i); #1;
        alu_exp.push_back({3'd1, 10'h15, 64'hDEADBEEF, 8'hFF});
        alu_req_i = 1'b1; alu_id_i = 3'd1; alu_addr_i = 10'h15;
        alu_wdata_i = 64'hDEADBEEF; alu_be_i = 8'hFF;
        @(negedge clk_i);
        check("single_alu_gnt", 96'(alu_gnt_o), 96'd1);
        check("single_req_same_cycle", 96'(vrf_req_o), 96'(Byp));
        @(posedge clk_i); #1;
        alu_req_i = 1'b0;
        @(negedge clk_i);
        check("single_req_next_cycle", 96'(vrf_req_o), 96'(!Byp));
        check("single_src", 96'(vrf_src_o), 96'd0);
        check("single_alu_cnt", 96'(alu_cnt_o), Byp ? 96'd0 : 96'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("single_idle_after", 96'(idle_o), 96'd1);
        check("single_drained", 96'(alu_exp.size()), 96'd0);

        // Both sources streaming: strict alternation starting with ALU
        do_reset();
        src_log.delete();
        fork
            for (int i = 0; i < 4; i++) send_alu(3'(i), 10'h100 + 10'(i), 64'hA000 + 64'(i), 8'h0F);
            for (int i = 0; i < 4; i++) send_mfpu(3'(i), 10'h200 + 10'(i), 64'hB000 + 64'(i), 8'hF0);
        join
        drain("stream_drain");
        check("stream_count", 96'(src_log.size()), 96'd8);
        for (int i = 0; i < 8 && i < src_log.size(); i++)
            check("stream_order", 96'(src_log[i]), 96'(i % 2));

        // VRF stall: both FIFOs fill, grants drop, nothing lost on release
        vrf_gnt_i = 1'b0;
        fork
            for (int i = 0; i < 3; i++) send_alu(3'(i), 10'h300 + 10'(i), 64'hC000 + 64'(i), 8'h3C);
            for (int i = 0; i < 3; i++) send_mfpu(3'(i), 10'h380 + 10'(i), 64'hD000 + 64'(i), 8'hC3);
            begin
                repeat (4) @(posedge clk_i);
                @(negedge clk_i);
                check("stall_alu_full", 96'(alu_cnt_o), 96'd2);
                check("stall_mfpu_full", 96'(mfpu_cnt_o), 96'd2);
                check("stall_gnts_low", 96'({alu_gnt_o, mfpu_gnt_o}), 96'd0);
                check("stall_req_high", 96'(vrf_req_o), 96'd1);
                @(posedge clk_i); #1;
                vrf_gnt_i = 1'b1;
            end
        join
        drain("stall_drain");

        // ALU push and pop together at count 1, pointers wrapping
        vrf_gnt_i = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send_alu(3'(i), 10'h040 + 10'(i), 64'hE000 + 64'(i), 8'h55);
            begin
                @(posedge clk_i); #1;
                vrf_gnt_i = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    check("pushpop_cnt", 96'(alu_cnt_o), 96'd1);
                end
            end
        join
        drain("pushpop_drain");

        // Reset with two ALU entries buffered
        vrf_gnt_i = 1'b0;
        send_alu(3'd5, 10'h3F0, 64'h1111, 8'h01);
        send_alu(3'd6, 10'h3F1, 64'h2222, 8'h02);
        @(negedge clk_i);
        check("prerst_cnt", 96'(alu_cnt_o), 96'd2);
        @(posedge clk_i); #1;
        do_reset();
        @(negedge clk_i);
        check("postrst_req", 96'(vrf_req_o), 96'd0);
        check("postrst_cnts", 96'({alu_cnt_o, mfpu_cnt_o}), 96'd0);
        check("postrst_idle", 96'(idle_o), 96'd1);
        @(posedge clk_i); #1;
        vrf_gnt_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("postrst_still_idle", 96'(idle_o), 96'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
